ocs_8x8_req_sched: RTL and testbench

Front-end scheduler for the 8x8 optical switch controller. Collects per-port destination requests and resolves output contention with a round-robin pointer. Completes the winners into a full conflict-free permutation, issues it to the controller's i_8x8_req/i_8x8_valid, and waits for o_grant_valid. Holds the configuration for a dwell time, then returns per-port grants to the requesters.

---
 rtl/ocs_sched_pkg.sv | 27 ++
 rtl/ocs_perm_builder.sv | 93 +++++++++
 rtl/ocs_8x8_req_sched.sv | 165 ++++++++++++++++
 tb/tb_ocs_8x8_req_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ocs_sched_pkg.sv
// Shared state enum, port/field constants and 3-bit field pack/unpack helpers
// for the 8x8 optical switch request scheduler.
package ocs_sched_pkg;

  localparam int PORTNUM   = 8;
  localparam int DSTWIDTH  = 3;
  localparam int PERMWIDTH = PORTNUM * DSTWIDTH;

  typedef logic [DSTWIDTH-1:0]  dst_t;
  typedef logic [PERMWIDTH-1:0] perm_t;

  typedef enum logic [2:0] {
    IDLE, MATCH, FILL, ISSUE, WAIT, DWELL, DONE
  } state_t;

  function automatic dst_t get_dst(input perm_t v, input dst_t idx);
    return v[idx*DSTWIDTH +: DSTWIDTH];
  endfunction

  function automatic perm_t set_dst(input perm_t v, input dst_t idx, input dst_t d);
    perm_t r;
    r = v;
    r[idx*DSTWIDTH +: DSTWIDTH] = d;
    return r;
  endfunction

endpackage

// File: rtl/ocs_perm_builder.sv
// Round-robin match (8 steps) then lowest-free fill (8 steps) into a full permutation.
// One port per cycle; no backpressure, the caller sequences start/match/fill.
module ocs_perm_builder
  import ocs_sched_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [PORTNUM-1:0]   i_req,
  input  logic [PERMWIDTH-1:0] i_dst,
  input  logic [DSTWIDTH-1:0]  i_rr_ptr,
  input  logic                 i_match,
  input  logic                 i_fill,
  output logic                 o_last_step,
  output logic [PERMWIDTH-1:0] o_perm_nxt,
  output logic [PORTNUM-1:0]   o_won
);

  logic [PORTNUM-1:0]   req_q, req_d;
  logic [PERMWIDTH-1:0] dst_q, dst_d;
  logic [PORTNUM-1:0]   out_used_q, out_used_d;
  logic [PORTNUM-1:0]   in_done_q, in_done_d;
  logic [PORTNUM-1:0]   won_q, won_d;
  logic [PERMWIDTH-1:0] perm_q, perm_d;
  logic [DSTWIDTH-1:0]  step_q, step_d;
  logic [DSTWIDTH-1:0]  port_k, dst_k, free_idx;

  always_comb begin
    req_d      = req_q;
    dst_d      = dst_q;
    out_used_d = out_used_q;
    in_done_d  = in_done_q;
    won_d      = won_q;
    perm_d     = perm_q;
    step_d     = step_q;
    port_k     = i_rr_ptr + step_q;
    dst_k      = get_dst(dst_q, port_k);
    free_idx   = '0;
    for (int i = PORTNUM - 1; i >= 0; i--) begin
      if (!out_used_q[i]) free_idx = dst_t'(i);
    end

    if (i_start) begin
      req_d      = i_req;
      dst_d      = i_dst;
      out_used_d = '0;
      in_done_d  = '0;
      won_d      = '0;
      step_d     = '0;
    end else if (i_match) begin
      if (req_q[port_k] && !out_used_q[dst_k]) begin
        perm_d            = set_dst(perm_q, port_k, dst_k);
        out_used_d[dst_k] = 1'b1;
        in_done_d[port_k] = 1'b1;
        won_d[port_k]     = 1'b1;
      end
      step_d = step_q + 1'b1;
    end else if (i_fill) begin
      // Free outputs always equal unserved inputs, so free_idx is valid here
      if (!in_done_q[step_q]) begin
        perm_d               = set_dst(perm_q, step_q, free_idx);
        out_used_d[free_idx] = 1'b1;
        in_done_d[step_q]    = 1'b1;
      end
      step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_q      <= '0;
      dst_q      <= '0;
      out_used_q <= '0;
      in_done_q  <= '0;
      won_q      <= '0;
      perm_q     <= '0;
      step_q     <= '0;
    end else begin
      req_q      <= req_d;
      dst_q      <= dst_d;
      out_used_q <= out_used_d;
      in_done_q  <= in_done_d;
      won_q      <= won_d;
      perm_q     <= perm_d;
      step_q     <= step_d;
    end
  end

  assign o_last_step = (step_q == 3'd7);
  assign o_perm_nxt  = perm_d;
  assign o_won       = won_q;

endmodule

// File: rtl/ocs_8x8_req_sched.sv
// Request scheduler: issue 17 cycles after a request, waits on controller grant (timeout), dwells, pulses grants.
// Optional OCS_SCHED_SKIP_SAME_EN: skip issue/wait when the permutation matches the last granted one.
module ocs_8x8_req_sched
  import ocs_sched_pkg::*;
#(
  parameter int P_PORTNUM      = 8,
  parameter int P_DSTWIDTH     = 3,
  parameter int P_DWELL_CYCLES = 16,
  parameter int P_TIMEOUT      = 1024
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [P_PORTNUM-1:0]            i_port_req,
  input  logic [P_PORTNUM*P_DSTWIDTH-1:0] i_port_dst,
  output logic [P_PORTNUM-1:0]            o_port_grant,
  output logic [P_PORTNUM*P_DSTWIDTH-1:0] o_8x8_req,
  output logic                            o_8x8_valid,
  input  logic                            i_grant_valid,
  output logic                            o_busy,
  output logic                            o_err_timeout
);

  localparam int TW = $clog2(P_TIMEOUT + 1);
  localparam int DW = $clog2(P_DWELL_CYCLES + 1);

  state_t               state_q, state_d;
  logic [TW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]        dwell_cnt_q, dwell_cnt_d;
  logic [DSTWIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PERMWIDTH-1:0] req_q, req_d;
  logic                 err_q, err_d;
`ifdef OCS_SCHED_SKIP_SAME_EN
  logic [PERMWIDTH-1:0] last_perm_q, last_perm_d;
  logic                 last_vld_q, last_vld_d;
`endif

  logic                 start, last_step, found;
  logic [PERMWIDTH-1:0] perm_nxt;
  logic [PORTNUM-1:0]   won;
  logic [DSTWIDTH-1:0]  scan_idx, first_won;

  assign start = (state_q == IDLE) && (|i_port_req);

  ocs_perm_builder u_builder (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (start),
    .i_req       (i_port_req),
    .i_dst       (i_port_dst),
    .i_rr_ptr    (rr_ptr_q),
    .i_match     (state_q == MATCH),
    .i_fill      (state_q == FILL),
    .o_last_step (last_step),
    .o_perm_nxt  (perm_nxt),
    .o_won       (won)
  );

  // First winner in scan order from the current pointer
  always_comb begin
    found     = 1'b0;
    first_won = rr_ptr_q;
    scan_idx  = '0;
    for (int i = 0; i < P_PORTNUM; i++) begin
      scan_idx = rr_ptr_q + dst_t'(i);
      if (!found && won[scan_idx]) begin
        first_won = scan_idx;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    req_d       = req_q;
    err_d       = err_q;
`ifdef OCS_SCHED_SKIP_SAME_EN
    last_perm_d = last_perm_q;
    last_vld_d  = last_vld_q;
`endif
    case (state_q)
      IDLE:  if (start) state_d = MATCH;
      MATCH: if (last_step) state_d = FILL;
      FILL: begin
        if (last_step) begin
`ifdef OCS_SCHED_SKIP_SAME_EN
          if (last_vld_q && (perm_nxt == last_perm_q)) begin
            state_d     = DWELL;
            dwell_cnt_d = '0;
          end else begin
            state_d = ISSUE;
            req_d   = perm_nxt;
          end
`else
          state_d = ISSUE;
          req_d   = perm_nxt;
`endif
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (wait_cnt_q == TW'(P_TIMEOUT)) begin
          state_d = IDLE;
        end else if (i_grant_valid) begin
          state_d     = DWELL;
          dwell_cnt_d = '0;
`ifdef OCS_SCHED_SKIP_SAME_EN
          last_perm_d = req_q;
          last_vld_d  = 1'b1;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == TW'(P_TIMEOUT - 1)) err_d = 1'b1;
        end
      end
      DWELL: begin
        if (dwell_cnt_q == DW'(P_DWELL_CYCLES - 1)) state_d = DONE;
        else dwell_cnt_d = dwell_cnt_q + 1'b1;
      end
      DONE: begin
        rr_ptr_d = first_won + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      dwell_cnt_q <= '0;
      rr_ptr_q    <= '0;
      req_q       <= '0;
      err_q       <= 1'b0;
`ifdef OCS_SCHED_SKIP_SAME_EN
      last_perm_q <= '0;
      last_vld_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      req_q       <= req_d;
      err_q       <= err_d;
`ifdef OCS_SCHED_SKIP_SAME_EN
      last_perm_q <= last_perm_d;
      last_vld_q  <= last_vld_d;
`endif
    end
  end

  assign o_port_grant  = (state_q == DONE) ? won : '0;
  assign o_8x8_req     = req_q;
  assign o_8x8_valid   = (state_q == ISSUE);
  assign o_busy        = (state_q != IDLE);
  assign o_err_timeout = err_q;

endmodule

// File: tb/tb_ocs_8x8_req_sched.sv
// Directed bench for ocs_8x8_req_sched: hand-computed permutations, grants, latency and timeout.
`timescale 1ns/1ps
module tb_ocs_8x8_req_sched;

  localparam int P_TIMEOUT = 1024;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_port_req;
  logic [23:0] i_port_dst;
  logic [7:0]  o_port_grant;
  logic [23:0] o_8x8_req;
  logic        o_8x8_valid;
  logic        i_grant_valid;
  logic        o_busy;
  logic        o_err_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int saw;

  always #5 i_clk = ~i_clk;

  ocs_8x8_req_sched dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_port_req    (i_port_req),
    .i_port_dst    (i_port_dst),
    .o_port_grant  (o_port_grant),
    .o_8x8_req     (o_8x8_req),
    .o_8x8_valid   (o_8x8_valid),
    .i_grant_valid (i_grant_valid),
    .o_busy        (o_busy),
    .o_err_timeout (o_err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Called in the IDLE cycle that first sees the request; returns in the ISSUE cycle.
  task automatic issue_phase(input logic [23:0] exp_perm, input string tag);
    step(16);
    chk({tag, "_pre_vld"}, o_8x8_valid, 1'b0);
    step(1);
    chk({tag, "_vld"}, o_8x8_valid, 1'b1);
    chk({tag, "_perm"}, o_8x8_req, exp_perm);
  endtask

  // Full round; returns in the IDLE cycle after DONE with i_port_req = next_req.
  task automatic run_round(input logic [7:0] req, input logic [23:0] dst,
                           input logic [23:0] exp_perm, input int gd,
                           input logic [7:0] exp_grant, input logic [7:0] next_req,
                           input string tag);
    i_port_req = req;
    i_port_dst = dst;
    issue_phase(exp_perm, tag);
    step(1);
    chk({tag, "_vld_low"}, o_8x8_valid, 1'b0);
    step(gd - 1);
    i_grant_valid = 1'b1;
    step(1);
    i_grant_valid = 1'b0;
    step(15);
    chk({tag, "_grant_early"}, o_port_grant, 8'h00);
    chk({tag, "_req_held"}, o_8x8_req, exp_perm);
    step(1);
    chk({tag, "_grant"}, o_port_grant, exp_grant);
    i_port_req = next_req;
    step(1);
    chk({tag, "_grant_pulse"}, o_port_grant, 8'h00);
    chk({tag, "_busy_idle"}, o_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst         = 1'b1;
    i_port_req    = 8'h00;
    i_port_dst    = 24'h000000;
    i_grant_valid = 1'b0;
    step(3);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_vld", o_8x8_valid, 1'b0);
    chk("rst_req", o_8x8_req, 24'h000000);
    chk("rst_grant", o_port_grant, 8'h00);
    chk("rst_err", o_err_timeout, 1'b0);
    i_rst = 1'b0;

    // No requests: stays idle, stray grant_valid ignored
    i_port_dst    = 24'hFFFFFF;
    i_grant_valid = 1'b1;
    step(20);
    chk("zero_req_busy", o_busy, 1'b0);
    chk("zero_req_vld", o_8x8_valid, 1'b0);
    i_grant_valid = 1'b0;

    // Ports 1 and 6 both want output 3; pointer starts at 0 then moves to 2
    run_round(8'h42, 24'h0C0018, 24'hFAC458, 2, 8'h02, 8'h42, "rr1");
    run_round(8'h42, 24'h0C0018, 24'hEF5888, 2, 8'h40, 8'h00, "rr2");

    run_round(8'h04, 24'h000140, 24'hFA3548, 3, 8'h04, 8'h00, "p2");
    run_round(8'hFF, 24'hFAC688, 24'hFAC688, 1, 8'hFF, 8'h00, "ident");

    // Controller never grants
    i_port_req = 8'h01;
    i_port_dst = 24'h000007;
    issue_phase(24'hD63447, "tmo");
    i_port_req = 8'h00;
    saw = 0;
    repeat (P_TIMEOUT) begin
      step(1);
      if (o_port_grant != 8'h00) saw = 1;
    end
    chk("tmo_err_early", o_err_timeout, 1'b0);
    chk("tmo_busy_wait", o_busy, 1'b1);
    step(1);
    chk("tmo_err", o_err_timeout, 1'b1);
    chk("tmo_busy_last", o_busy, 1'b1);
    step(1);
    chk("tmo_busy_drop", o_busy, 1'b0);
    chk("tmo_err_sticky", o_err_timeout, 1'b1);
    chk("tmo_no_grant", saw, 0);

    // Reset in the middle of DWELL
    i_port_req = 8'h04;
    i_port_dst = 24'h000140;
    issue_phase(24'hFA3548, "rstd");
    i_port_req = 8'h00;
    step(1);
    i_grant_valid = 1'b1;
    step(1);
    i_grant_valid = 1'b0;
    step(5);
    chk("rstd_busy_dwell", o_busy, 1'b1);
    i_rst = 1'b1;
    step(1);
    i_rst = 1'b0;
    chk("rstd_busy", o_busy, 1'b0);
    chk("rstd_vld", o_8x8_valid, 1'b0);
    chk("rstd_req", o_8x8_req, 24'h000000);
    chk("rstd_grant", o_port_grant, 8'h00);
    chk("rstd_err", o_err_timeout, 1'b0);
    saw = 0;
    repeat (30) begin
      step(1);
      if (o_port_grant != 8'h00) saw = 1;
    end
    chk("rstd_no_grant", saw, 0);
    run_round(8'h42, 24'h0C0018, 24'hFAC458, 2, 8'h02, 8'h00, "post_rst");

`ifdef OCS_SCHED_SKIP_SAME_EN
    run_round(8'hFF, 24'hFAC688, 24'hFAC688, 1, 8'hFF, 8'hFF, "skip1");
    saw = 0;
    repeat (33) begin
      step(1);
      if (o_8x8_valid) saw++;
    end
    chk("skip_no_vld", saw, 0);
    chk("skip_grant", o_port_grant, 8'hFF);
    i_port_req = 8'h00;
    step(2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
